layer5_argmax: RTL and testbench

//   Sink for the FC2 logit stream: consumes NUM_CLASSES signed INT32 logits per frame (index 0 first),

---
 rtl/mnist_pkg.sv | 15 +
 rtl/top2_tracker.sv | 47 ++++
 rtl/layer5_argmax.sv | 125 ++++++++++++
 tb/tb_layer5_argmax.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared constants for the MNIST inference pipeline.
//   NUM_CLASSES : logits per frame produced by the FC2 layer
//   LOGIT_W     : logit width, signed two's complement
//   IDX_W       : class index width
//   CNT_W       : frame counter width
//   LOGIT_MIN   : most-negative logit, used as the empty-tracker value
//   SAT_MAX     : largest positive logit, used to saturate the margin
package mnist_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int LOGIT_W     = 32;
  localparam int IDX_W       = $clog2(NUM_CLASSES);
  localparam int CNT_W       = 16;
  localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = 32'sh8000_0000;
  localparam logic signed [LOGIT_W-1:0] SAT_MAX   = 32'sh7FFF_FFFF;
endpackage

// File: rtl/top2_tracker.sv
// Combinational top-2 tracker: given the current largest and second-largest
// logits and the incoming logit, produces the next max/second/class.
// Ports:
//   in_data    : incoming signed logit
//   cur_max    : current largest logit of the frame
//   cur_second : current second-largest logit of the frame
//   cur_cls    : class index of cur_max
//   idx        : position of in_data within the frame
//   first      : in_data is the first logit of a frame (restart tracking)
//   nxt_max, nxt_second, nxt_cls : updated tracker values
module top2_tracker #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] cur_max,
  input  logic signed [DATA_W-1:0] cur_second,
  input  logic        [IDX_W-1:0]  cur_cls,
  input  logic        [IDX_W-1:0]  idx,
  input  logic                     first,
  output logic signed [DATA_W-1:0] nxt_max,
  output logic signed [DATA_W-1:0] nxt_second,
  output logic        [IDX_W-1:0]  nxt_cls
);

  localparam logic signed [DATA_W-1:0] TRK_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Strict compares: on a tie the earlier index keeps the max and the equal
  // value falls into second, which makes the margin 0.
  always_comb begin
    nxt_max    = cur_max;
    nxt_second = cur_second;
    nxt_cls    = cur_cls;
    if (first) begin
      nxt_max    = in_data;
      nxt_second = TRK_MIN;
      nxt_cls    = '0;
    end else if (in_data > cur_max) begin
      nxt_second = cur_max;
      nxt_max    = in_data;
      nxt_cls    = idx;
    end else if (in_data > cur_second) begin
      nxt_second = in_data;
    end
  end

endmodule

// File: rtl/layer5_argmax.sv
// Argmax sink for the FC2 logit stream. Consumes NUM_CLASSES signed logits
// per frame (index 0 first), tracks the top two on the fly and publishes the
// predicted class, max logit and saturated margin on a result port.
// The input is never stalled; a frame that completes while an unaccepted
// result is pending is dropped and flagged on the sticky overrun output.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   valid_in       : one logit per asserted cycle, gaps allowed
//   in_data        : signed logit
//   result_ready   : consumer ready
//   result_valid   : result register holds an unaccepted result
//   result_class   : argmax index
//   result_max     : max logit, signed
//   result_margin  : max minus second-max, unsigned, saturated
//   busy           : a frame is partially received
//   overrun        : sticky, a completed frame was dropped
//   frame_cnt      : frames completed (including dropped), wraps
module layer5_argmax #(
  parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES,
  parameter int DATA_W      = mnist_pkg::LOGIT_W,
  parameter int IDX_W       = mnist_pkg::IDX_W,
  parameter int CNT_W       = mnist_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     result_ready,
  output logic                     result_valid,
  output logic        [IDX_W-1:0]  result_class,
  output logic signed [DATA_W-1:0] result_max,
  output logic        [DATA_W-1:0] result_margin,
  output logic                     busy,
  output logic                     overrun,
  output logic        [CNT_W-1:0]  frame_cnt
);

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [DATA_W-1:0] TRK_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]        SAT_VAL  = {1'b0, {(DATA_W-1){1'b1}}};

  logic        [IDX_W-1:0]  idx_q;
  logic signed [DATA_W-1:0] max_q, second_q;
  logic        [IDX_W-1:0]  cls_q;
  logic signed [DATA_W-1:0] nxt_max, nxt_second;
  logic        [IDX_W-1:0]  nxt_cls;
  logic        [DATA_W:0]   diff;
  logic        [DATA_W-1:0] margin;
  logic                     frame_done;
  logic                     slot_free;

  top2_tracker #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_tracker (
    .in_data    (in_data),
    .cur_max    (max_q),
    .cur_second (second_q),
    .cur_cls    (cls_q),
    .idx        (idx_q),
    .first      (idx_q == '0),
    .nxt_max    (nxt_max),
    .nxt_second (nxt_second),
    .nxt_cls    (nxt_cls)
  );

  // max >= second always holds, so the DATA_W+1 bit difference is
  // non-negative; anything with bit DATA_W-1 or above set exceeds SAT_VAL.
  always_comb begin
    diff   = {nxt_max[DATA_W-1], nxt_max} - {nxt_second[DATA_W-1], nxt_second};
    margin = (diff[DATA_W] | diff[DATA_W-1]) ? SAT_VAL : diff[DATA_W-1:0];
  end

  // Result handshake: a result transfers on any cycle where result_valid and
  // result_ready are both high; result_valid then clears on the next edge
  // unless a new frame completes in that same cycle and reloads the slot.
  // While result_valid is high and result_ready low, all result fields hold.
  // result_ready is ignored while result_valid is low.
  assign frame_done = valid_in && (idx_q == LAST_IDX);
  assign slot_free  = !result_valid || result_ready;
  assign busy       = (idx_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      max_q    <= TRK_MIN;
      second_q <= TRK_MIN;
      cls_q    <= '0;
    end else if (valid_in) begin
      idx_q    <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      max_q    <= nxt_max;
      second_q <= nxt_second;
      cls_q    <= nxt_cls;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid  <= 1'b0;
      result_class  <= '0;
      result_max    <= '0;
      result_margin <= '0;
      overrun       <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      if (frame_done) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (frame_done && slot_free) begin
        result_valid  <= 1'b1;
        result_class  <= nxt_cls;
        result_max    <= nxt_max;
        result_margin <= margin;
      end else begin
        if (result_valid && result_ready) begin
          result_valid <= 1'b0;
        end
        if (frame_done) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer5_argmax.sv
// Testbench for layer5_argmax: directed frames plus randomized traffic,
// checked against a frame-level argmax / top-2 reference model.
module tb_layer5_argmax;

  localparam int NC    = 10;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int CW    = 16;
  localparam int RES_W = IW + 2 * DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          result_ready = 1'b0;
  logic          result_valid;
  logic [IW-1:0] result_class;
  logic [DW-1:0] result_max;
  logic [DW-1:0] result_margin;
  logic          busy;
  logic          overrun;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  layer5_argmax #(
    .NUM_CLASSES (NC),
    .DATA_W      (DW),
    .IDX_W       (IW),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .in_data       (in_data),
    .result_ready  (result_ready),
    .result_valid  (result_valid),
    .result_class  (result_class),
    .result_max    (result_max),
    .result_margin (result_margin),
    .busy          (busy),
    .overrun       (overrun),
    .frame_cnt     (frame_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int               n_cmp = 0;
  int               n_err = 0;
  logic [RES_W-1:0] exp_q[$];
  longint           frame_q[$];
  bit               m_valid = 0;
  bit               m_overrun = 0;
  int               m_frame_cnt = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Top-2 of the frame as a multiset: max, lowest index holding it, and the
  // largest value among the remaining positions.
  function automatic logic [RES_W-1:0] ref_result();
    longint mx = frame_q[0];
    longint sec = -(64'sd1 <<< 40);
    longint mg;
    int     cls = 0;
    logic [IW-1:0] c4;
    logic [DW-1:0] mx32, mg32;
    foreach (frame_q[i]) if (frame_q[i] > mx) mx = frame_q[i];
    for (int i = NC - 1; i >= 0; i--) if (frame_q[i] == mx) cls = i;
    foreach (frame_q[i]) if (i != cls && frame_q[i] > sec) sec = frame_q[i];
    mg = mx - sec;
    if (mg > 64'sd2147483647) mg = 64'sd2147483647;
    c4   = cls[IW-1:0];
    mx32 = mx[DW-1:0];
    mg32 = mg[DW-1:0];
    return {c4, mx32, mg32};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs, compare DUT state with the model, then
  // advance the model by the rising edge that follows.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy);
    @(negedge clk);
    valid_in     = v;
    in_data      = d;
    result_ready = rdy;
    check("result_valid", 72'(result_valid), 72'(m_valid));
    if (m_valid)
      check("result_fields", 72'({result_class, result_max, result_margin}), 72'(exp_q[0]));
    check("busy", 72'(busy), 72'(frame_q.size() != 0));
    check("overrun", 72'(overrun), 72'(m_overrun));
    check("frame_cnt", 72'(frame_cnt), 72'(m_frame_cnt % (1 << CW)));
    if (v) frame_q.push_back(longint'($signed(d)));
    if (frame_q.size() == NC) begin
      logic [RES_W-1:0] r;
      r = ref_result();
      frame_q.delete();
      m_frame_cnt++;
      if (!m_valid || rdy) begin
        if (m_valid) void'(exp_q.pop_front());
        exp_q.push_back(r);
        m_valid = 1;
      end else begin
        m_overrun = 1;
      end
    end else if (m_valid && rdy) begin
      void'(exp_q.pop_front());
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    result_ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 72'(result_valid), 72'(0));
    check("rst_fields", 72'({result_class, result_max, result_margin}), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_overrun", 72'(overrun), 72'(0));
    check("rst_frame_cnt", 72'(frame_cnt), 72'(0));
    rst_n = 1'b1;
    exp_q.delete();
    frame_q.delete();
    m_valid     = 0;
    m_overrun   = 0;
    m_frame_cnt = 0;
  endtask

  task automatic send_frame(input int vals[NC], input bit rdy, input bit rdy_last);
    for (int i = 0; i < NC; i++)
      step(1'b1, vals[i], (i == NC - 1) ? rdy_last : rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  // ---------------- stimulus ----------------
  int t1[NC] = '{5, -3, 90, 7, 90, -100, 2, 0, 1, 4};
  int t2[NC] = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
  int t3[NC];
  int f3[NC] = '{1, 2, 3, 50, 4, 5, 6, 7, 8, 9};
  int f8[NC] = '{0, 0, 0, 0, 0, 0, 0, 0, 99, -1};
  int t6[NC] = '{-5, -4, -3, -2, -1, 0, 77, 3, 2, 1};

  initial begin
    t3[0] = 32'h7FFF_FFFF;
    for (int i = 1; i < NC; i++) t3[i] = 32'h8000_0000;

    do_reset();

    // Tie on 90: lowest index wins, margin 0; result one cycle after logit 9.
    send_frame(t1, 1'b1, 1'b1);
    idle(2, 1'b1);
    // All equal.
    send_frame(t2, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Extreme values: saturated margin.
    send_frame(t3, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Back-to-back frames with no consumer: second frame dropped.
    do_reset();
    send_frame(f3, 1'b0, 1'b0);
    send_frame(f8, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("overrun_sticky", 72'(overrun), 72'(1));
    check("held_class", 72'(result_class), 72'(3));
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Second frame completes in the acceptance cycle of the first.
    do_reset();
    send_frame(f3, 1'b0, 1'b0);
    send_frame(f8, 1'b0, 1'b1);
    idle(1, 1'b0);
    check("reload_class", 72'(result_class), 72'(8));
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Reset mid-frame discards the partial frame.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'd1000 + i, 1'b1);
    do_reset();
    send_frame(t6, 1'b1, 1'b1);
    idle(3, 1'b1);
    check("single_frame_cnt", 72'(frame_cnt), 72'(1));

    // Randomized traffic: gaps, random backpressure, small-range values to
    // provoke ties and full-range values to provoke saturation.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [DW-1:0] d;
      if ($urandom_range(0, 1) == 0) d = DW'($urandom_range(0, 6)) - DW'(3);
      else                           d = $urandom;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
    end
    idle(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
